// File: rtl/line_length_feature_if.sv
// Sample-in / feature-out bundle for the line-length extractor.
// The front end drives en/din through master; the extractor is the slave.
interface line_length_feature_if #(
   parameter int DATA_WIDTH   = 16,
   parameter int OUTPUT_WIDTH = 25
);
   logic                           en;
   logic signed [DATA_WIDTH-1:0]   din;
   logic signed [OUTPUT_WIDTH-1:0] dout;
   logic                           data_valid;

   modport master (output en, din, input dout, data_valid);
   modport slave  (input en, din, output dout, data_valid);
endinterface

// File: rtl/line_length_feature.sv
// Line length over the last 8 blocks of 32 absolute first differences.
// A block completes on one edge; dout/data_valid follow on the next edge.
module line_length_feature #(
   parameter int DATA_WIDTH   = 16,
   parameter int MID_WIDTH    = 22,
   parameter int OUTPUT_WIDTH = 25
) (
   input logic                   clk,
   input logic                   rst,
   line_length_feature_if.slave  bus
);
   localparam int NBLK   = 8;
   localparam int BLK    = 32;
   localparam int CW     = $clog2(BLK);
   localparam int STAGES = 2;

   logic signed [DATA_WIDTH-1:0]        prev;
   logic                                primed;
   logic [CW-1:0]                       cnt;
   logic [MID_WIDTH-1:0]                acc;
   logic [NBLK-1:0][MID_WIDTH-1:0]      blk;
   logic [OUTPUT_WIDTH-1:0]             total;
   logic [OUTPUT_WIDTH-1:0]             dout_q;
   logic [STAGES:1]                     vld_pipe;

   logic signed [DATA_WIDTH:0]          diff;
   logic [DATA_WIDTH:0]                 ad;
   logic [MID_WIDTH-1:0]                bsum;
   logic                                blk_end;

   // One extra bit on the difference keeps full-scale swings from overflowing.
   assign diff    = {bus.din[DATA_WIDTH-1], bus.din} - {prev[DATA_WIDTH-1], prev};
   assign ad      = diff[DATA_WIDTH] ? (~diff + (DATA_WIDTH+1)'(1)) : diff;
   assign bsum    = acc + {{(MID_WIDTH-DATA_WIDTH-1){1'b0}}, ad};
   assign blk_end = bus.en & primed & (cnt == CW'(BLK-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         prev     <= '0;
         primed   <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         blk      <= '0;
         total    <= '0;
         dout_q   <= '0;
         vld_pipe <= '0;
      end else begin
         // Output stage runs regardless of en so a pending update never stalls.
         vld_pipe <= {vld_pipe[STAGES-1:1], blk_end};
         if (vld_pipe[1])
            dout_q <= total;
         if (bus.en) begin
            prev   <= bus.din;
            primed <= 1'b1;
            if (primed) begin
               cnt <= cnt + CW'(1);
               if (blk_end) begin
                  acc   <= '0;
                  blk   <= {blk[NBLK-2:0], bsum};
                  total <= total + {{(OUTPUT_WIDTH-MID_WIDTH){1'b0}}, bsum}
                                 - {{(OUTPUT_WIDTH-MID_WIDTH){1'b0}}, blk[NBLK-1]};
               end else begin
                  acc <= bsum;
               end
            end
         end
      end
   end

   assign bus.dout       = dout_q;
   assign bus.data_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_line_length_feature.sv
// Random and directed stimulus against a windowed-sum model of the line length.
module tb_line_length_feature;
   localparam int OW = 25;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   line_length_feature_if #(.DATA_WIDTH(16), .OUTPUT_WIDTH(OW)) bus ();

   line_length_feature #(.DATA_WIDTH(16), .MID_WIDTH(22), .OUTPUT_WIDTH(OW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Model: every |diff| since reset; output is the sum of the newest <=256.
   int q[$];
   int m_prev;
   bit m_primed, m_pending, m_valid;
   int m_dout;

   function automatic int win_sum();
      int s = 0;
      int n = q.size();
      for (int i = (n > 256 ? n - 256 : 0); i < n; i++) s += q[i];
      return s;
   endfunction

   task automatic step(input bit r, input bit e, input int d);
      int df;
      rst = r; bus.en = e; bus.din = 16'(d);
      @(posedge clk);
      if (r) begin
         m_primed = 0; m_pending = 0; m_valid = 0; m_dout = 0; q.delete();
      end else begin
         m_valid = m_pending;
         if (m_pending) m_dout = win_sum();
         m_pending = 0;
         if (e) begin
            if (m_primed) begin
               df = d - m_prev;
               q.push_back(df < 0 ? -df : df);
               if (q.size() % 32 == 0) m_pending = 1;
            end
            m_primed = 1; m_prev = d;
         end
      end
      #1;
   endtask

   function automatic int rnd16();
      return int'($urandom_range(65535)) - 32768;
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         step(1, 1, rnd16());
         checks++;
         if (bus.dout !== '0 || bus.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset cyc%0d: dout=%0d vld=%b, want 0/0", i, bus.dout, bus.data_valid);
         end
      end
   endtask

   task automatic test_constant();
      int first = -1, pulses = 0;
      step(1, 0, 0);
      for (int i = 0; i < 400; i++) begin
         step(0, 1, 1234);
         checks++;
         if (bus.data_valid !== m_valid || bus.dout !== OW'(m_dout) || bus.dout !== '0) begin
            errors++;
            $display("FAIL const cyc%0d: dout=%0d vld=%b, want %0d/%b", i, bus.dout, bus.data_valid, m_dout, m_valid);
         end
         if (bus.data_valid === 1'b1) begin
            if (first < 0) first = i;
            pulses++;
         end
      end
      checks++;
      if (first != 33 || pulses != 12) begin
         errors++;
         $display("FAIL const_timing: first=%0d pulses=%0d, want 33/12", first, pulses);
      end
   endtask

   task automatic test_alternating(input int hi, input int lo, input int steps, input bit gate);
      int n = 0, last = -1, d, s = 0, bsz;
      bsz = 32 * (hi - lo);
      step(1, 0, 0);
      for (int j = 0; j < steps; j++) begin
         bit e;
         e = gate ? (j % 2 == 0) : 1'b1;
         d = (s % 2 == 0) ? hi : lo;
         if (!e) d = rnd16();
         step(0, e, d);
         if (e) s++;
         checks++;
         if (bus.data_valid !== m_valid || bus.dout !== OW'(m_dout)) begin
            errors++;
            $display("FAIL alt%0d_g%0d cyc%0d: dout=%0d vld=%b, want %0d/%b", hi, gate, j, bus.dout, bus.data_valid, m_dout, m_valid);
         end
         if (bus.data_valid === 1'b1) begin
            n++;
            checks++;
            if (bus.dout !== OW'((n < 8 ? n : 8) * bsz)) begin
               errors++;
               $display("FAIL alt%0d_g%0d pulse%0d: dout=%0d, want %0d", hi, gate, n, bus.dout, (n < 8 ? n : 8) * bsz);
            end
            if (last >= 0) begin
               checks++;
               if (j - last != (gate ? 64 : 32)) begin
                  errors++;
                  $display("FAIL alt%0d_g%0d spacing: got %0d, want %0d", hi, gate, j - last, gate ? 64 : 32);
               end
            end
            last = j;
         end
      end
      checks++;
      if (n < 9) begin
         errors++;
         $display("FAIL alt%0d_g%0d pulse_count: got %0d, want >=9", hi, gate, n);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      step(1, 0, 0);
      for (int i = 0; i < 100; i++) step(0, 1, (i % 2 == 0) ? 100 : -100);
      step(1, 1, rnd16());
      checks++;
      if (bus.dout !== '0 || bus.data_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_clear: dout=%0d vld=%b, want 0/0", bus.dout, bus.data_valid);
      end
      for (int i = 0; i < 35; i++) begin
         step(0, 1, (i % 2 == 0) ? 100 : -100);
         if (bus.data_valid === 1'b1) begin
            n++;
            checks++;
            if (i != 33 || bus.dout !== OW'(6400)) begin
               errors++;
               $display("FAIL rstmid_pulse: cyc=%0d dout=%0d, want 33/6400", i, bus.dout);
            end
         end
      end
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL rstmid_count: got %0d pulses, want 1", n);
      end
   endtask

   task automatic test_random();
      step(1, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         bit r, e;
         r = ($urandom_range(999) == 0);
         e = ($urandom_range(3) != 0);
         step(r, e, rnd16());
         checks++;
         if (bus.data_valid !== m_valid || bus.dout !== OW'(m_dout)) begin
            errors++;
            $display("FAIL random cyc%0d: dout=%0d vld=%b, want %0d/%b", i, bus.dout, bus.data_valid, m_dout, m_valid);
         end
      end
   endtask

   initial begin
      rst = 1'b1; bus.en = 1'b0; bus.din = '0;
      test_reset();
      test_constant();
      test_alternating(100, -100, 323, 1'b0);
      test_alternating(32767, -32768, 290, 1'b0);
      test_alternating(100, -100, 580, 1'b1);
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
